// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single RegFile write port between the pipeline writeback stage (P)
// and the multi-cycle mult/div unit (M). P has fixed priority, but M is
// force-granted once it has been held off for STARVE_LIMIT consecutive cycles.
// A 32-entry pending-write scoreboard tracks in-flight M ops so decode can
// stall on RAW hazards.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    output logic        p_ready,
    input  logic        m_valid,
    input  logic [4:0]  m_wa,
    input  logic [31:0] m_wd,
    output logic        m_ready,
    input  logic        m_issue,
    input  logic [4:0]  m_issue_wa,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        hazard,
    output logic [31:0] pending,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    typedef enum logic [0:0] {
        P_PRI = 1'b0,
        M_PRI = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              p_grant_s, m_grant_s;
    logic              xfer_s;
    logic [4:0]        xfer_wa_s;
    logic [31:0]       xfer_wd_s;
    logic [31:0]       pending_r, pending_s;
    logic              rf_we_r;
    logic [4:0]        rf_wa_r;
    logic [31:0]       rf_wd_r;

    // Arbitration: grant selection, starvation counter and priority-state update.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        p_grant_s = 1'b0;
        m_grant_s = 1'b0;
        case (state_r)
            P_PRI: begin
                if (p_valid) begin
                    p_grant_s = 1'b1;
                end else if (m_valid) begin
                    m_grant_s = 1'b1;
                end else begin
                    p_grant_s = 1'b0;
                end
                // Count only the cycles where M is waiting behind a P grant.
                if (m_valid && p_grant_s) begin
                    if (cnt_r < LIMIT_C) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    cnt_s = {CNT_W{1'b0}};
                end
                if (cnt_s == LIMIT_C) begin
                    state_s = M_PRI;
                end else begin
                    state_s = P_PRI;
                end
            end
            M_PRI: begin
                // M wins if still requesting; either way priority returns to P.
                if (m_valid) begin
                    m_grant_s = 1'b1;
                end else if (p_valid) begin
                    p_grant_s = 1'b1;
                end else begin
                    m_grant_s = 1'b0;
                end
                cnt_s   = {CNT_W{1'b0}};
                state_s = P_PRI;
            end
            default: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = P_PRI;
            end
        endcase
    end

    // Write-port mux: selects the granted requester's address and data.
    always_comb begin
        xfer_s    = m_grant_s | p_grant_s;
        xfer_wa_s = 5'd0;
        xfer_wd_s = 32'd0;
        if (m_grant_s) begin
            xfer_wa_s = m_wa;
            xfer_wd_s = m_wd;
        end else if (p_grant_s) begin
            xfer_wa_s = p_wa;
            xfer_wd_s = p_wd;
        end else begin
            xfer_wa_s = rf_wa_r;
            xfer_wd_s = rf_wd_r;
        end
    end

    // Scoreboard next value: commit clears, issue sets afterwards so a newer op wins.
    always_comb begin
        pending_s = pending_r;
        if (m_grant_s) begin
            pending_s[m_wa] = 1'b0;
        end else begin
            pending_s = pending_r;
        end
        if (m_issue && (m_issue_wa != 5'd0)) begin
            pending_s[m_issue_wa] = 1'b1;
        end else begin
            pending_s = pending_s;
        end
        pending_s[0] = 1'b0;
    end

    // State, counter and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= P_PRI;
            cnt_r     <= {CNT_W{1'b0}};
            pending_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pending_r <= pending_s;
        end
    end

    // Registered RegFile write port; r0 writes are accepted but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r <= 1'b0;
            rf_wa_r <= 5'd0;
            rf_wd_r <= 32'd0;
        end else begin
            rf_we_r <= xfer_s && (xfer_wa_s != 5'd0);
            rf_wa_r <= xfer_wa_s;
            rf_wd_r <= xfer_wd_s;
        end
    end

    assign p_ready = p_grant_s;
    assign m_ready = m_grant_s;
    assign hazard  = pending_r[ra1] | pending_r[ra2];
    assign pending = pending_r;
    assign rf_we   = rf_we_r;
    assign rf_wa   = rf_wa_r;
    assign rf_wd   = rf_wd_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid, m_valid, m_issue;
    logic [4:0]  p_wa, m_wa, m_issue_wa, ra1, ra2;
    logic [31:0] p_wd, m_wd;
    logic        p_ready, m_ready, hazard, rf_we;
    logic [31:0] pending, rf_wd;
    logic [4:0]  rf_wa;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          waited;      // consecutive cycles M has been refused
    bit [31:0]   mpend;       // registers awaiting an M result
    bit          exp_we;
    bit [4:0]    exp_wa;
    bit [31:0]   exp_wd;
    bit          last_pg, last_mg;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_wa(p_wa), .p_wd(p_wd), .p_ready(p_ready),
        .m_valid(m_valid), .m_wa(m_wa), .m_wd(m_wd), .m_ready(m_ready),
        .m_issue(m_issue), .m_issue_wa(m_issue_wa),
        .ra1(ra1), .ra2(ra2), .hazard(hazard), .pending(pending),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    // M wins when it has waited long enough or when P is idle.
    function automatic bit model_mg();
        return m_valid && ((waited >= LIMIT) || !p_valid);
    endfunction

    function automatic bit model_pg();
        return p_valid && !model_mg();
    endfunction

    function automatic bit model_hazard();
        return mpend[ra1] | mpend[ra2];
    endfunction

    task automatic model_reset();
        waited = 0; mpend = '0; exp_we = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
    endtask

    // One clock: decide grants from current inputs, then apply the edge to the model.
    task automatic advance();
        bit pg, mg;
        mg = model_mg();
        pg = model_pg();
        @(posedge clk);
        if (mg) begin
            exp_we = (m_wa != 5'd0); exp_wa = m_wa; exp_wd = m_wd;
        end else if (pg) begin
            exp_we = (p_wa != 5'd0); exp_wa = p_wa; exp_wd = p_wd;
        end else begin
            exp_we = 1'b0;
        end
        waited = (m_valid && !mg) ? waited + 1 : 0;
        if (mg) mpend[m_wa] = 1'b0;
        if (m_issue && m_issue_wa != 5'd0) mpend[m_issue_wa] = 1'b1;
        last_pg = pg; last_mg = mg;
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0; m_valid = 1'b0; m_issue = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        p_wa = 5'd0; p_wd = 32'd0; m_wa = 5'd0; m_wd = 32'd0;
        m_issue_wa = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 || pending !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: we=%0b wa=%0d wd=%h pend=%h, required 0/0/0/0", rf_we, rf_wa, rf_wd, pending);
        end
        rst_n = 1'b1;
        // Build up an in-flight write and a pending bit, then reset mid-cycle.
        p_valid = 1'b1; p_wa = 5'd3; p_wd = 32'h45;
        m_issue = 1'b1; m_issue_wa = 5'd9;
        advance();
        checks++;
        if (rf_we !== 1'b1 || pending[9] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_setup: we=%0b pend9=%0b, required 1/1", rf_we, pending[9]);
        end
        m_issue = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || pending !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: we=%0b pend=%h, required 0/0", rf_we, pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        p_valid = 1'b1; p_wa = 5'd3; p_wd = 32'h45;
        #1;
        checks++;
        if (p_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: p_ready=%0b, required 1", p_ready);
        end
        advance();
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h45) begin
            errors++;
            $display("FAIL post_reset_write: we=%0b wa=%0d wd=%h, required 1/3/45", rf_we, rf_wa, rf_wd);
        end
        idle();
        advance();
    endtask

    task automatic test_r0_drop();
        p_valid = 1'b1; p_wa = 5'd0; p_wd = 32'd69;
        #1;
        checks++;
        if (p_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_p_ready: p_ready=%0b, required 1", p_ready);
        end
        advance();
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd69) begin
            errors++;
            $display("FAIL r0_p_write: we=%0b wa=%0d wd=%0d, required 0/0/69", rf_we, rf_wa, rf_wd);
        end
        p_valid = 1'b0; m_valid = 1'b1; m_wa = 5'd0; m_wd = 32'h77;
        #1;
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_m_ready: m_ready=%0b, required 1", m_ready);
        end
        advance();
        checks++;
        if (rf_we !== 1'b0 || rf_wd !== 32'h77) begin
            errors++;
            $display("FAIL r0_m_write: we=%0b wd=%h, required 0/77", rf_we, rf_wd);
        end
        m_valid = 1'b0; m_issue = 1'b1; m_issue_wa = 5'd0;
        advance();
        checks++;
        if (pending !== 32'd0) begin
            errors++;
            $display("FAIL r0_issue: pending=%h, required 0", pending);
        end
        idle();
        advance();
    endtask

    task automatic test_contention();
        bit exp_m;
        p_valid = 1'b1; m_valid = 1'b1; m_wa = 5'd10; m_wd = $urandom;
        for (int i = 0; i < 15; i++) begin
            p_wa = 5'((i % 31) + 1); p_wd = 32'(i);
            exp_m = ((i % 5) == 4);
            #1;
            checks++;
            if (m_ready !== exp_m || p_ready !== !exp_m) begin
                errors++;
                $display("FAIL contention_grant[%0d]: p_ready=%0b m_ready=%0b, required %0b/%0b", i, p_ready, m_ready, !exp_m, exp_m);
            end
            advance();
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== (exp_m ? 5'd10 : p_wa)) begin
                errors++;
                $display("FAIL contention_write[%0d]: we=%0b wa=%0d, required 1/%0d", i, rf_we, rf_wa, exp_m ? 5'd10 : p_wa);
            end
            if (exp_m) m_wd = $urandom;
        end
        idle();
        advance();
    endtask

    task automatic test_scoreboard();
        m_issue = 1'b1; m_issue_wa = 5'd5;
        advance();
        m_issue = 1'b0; ra1 = 5'd5; ra2 = 5'd0;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL sb_hazard_set: hazard=%0b, required 1", hazard);
        end
        m_valid = 1'b1; m_wa = 5'd5; m_wd = 32'hDEAD;
        #1;
        checks++;
        if (m_ready !== 1'b1 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL sb_commit_cycle: m_ready=%0b hazard=%0b, required 1/1", m_ready, hazard);
        end
        advance();
        m_valid = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0 || rf_wd !== 32'hDEAD || rf_we !== 1'b1 || pending[5] !== 1'b0) begin
            errors++;
            $display("FAIL sb_after_commit: hazard=%0b wd=%h we=%0b pend5=%0b, required 0/dead/1/0", hazard, rf_wd, rf_we, pending[5]);
        end
        advance();
    endtask

    task automatic test_same_cycle();
        m_issue = 1'b1; m_issue_wa = 5'd7;
        advance();
        checks++;
        if (pending[7] !== 1'b1) begin
            errors++;
            $display("FAIL same_setup: pend7=%0b, required 1", pending[7]);
        end
        m_valid = 1'b1; m_wa = 5'd7; m_wd = 32'h1234;
        advance();
        checks++;
        if (pending[7] !== 1'b1) begin
            errors++;
            $display("FAIL same_set_wins: pend7=%0b, required 1", pending[7]);
        end
        m_issue = 1'b0; m_wd = 32'h5678;
        advance();
        checks++;
        if (pending[7] !== 1'b0 || rf_wd !== 32'h5678) begin
            errors++;
            $display("FAIL same_clear: pend7=%0b wd=%h, required 0/5678", pending[7], rf_wd);
        end
        idle();
        advance();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            p_valid = 1'b1; p_wa = 5'(i); p_wd = 32'(i);
            advance();
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== 5'(i) || rf_wd !== 32'(i)) begin
                errors++;
                $display("FAIL b2b[%0d]: we=%0b wa=%0d wd=%0d, required 1/%0d/%0d", i, rf_we, rf_wa, rf_wd, i, i);
            end
        end
        idle();
        advance();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: we=%0b, required 0", rf_we);
        end
    endtask

    task automatic test_random();
        bit epg, emg, ehz;
        idle();
        last_pg = 1'b0; last_mg = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // A refused requester holds its request unchanged.
            if (!(p_valid && !last_pg)) begin
                p_valid = ($urandom_range(0, 9) < 7);
                p_wa = 5'($urandom_range(0, 31)); p_wd = $urandom;
            end
            if (!(m_valid && !last_mg)) begin
                m_valid = ($urandom_range(0, 1) == 1);
                m_wa = 5'($urandom_range(0, 31)); m_wd = $urandom;
            end
            m_issue = ($urandom_range(0, 3) == 0);
            m_issue_wa = 5'($urandom_range(0, 31));
            ra1 = 5'($urandom_range(0, 31)); ra2 = 5'($urandom_range(0, 31));
            #1;
            epg = model_pg(); emg = model_mg(); ehz = model_hazard();
            checks++;
            if (p_ready !== epg || m_ready !== emg || hazard !== ehz) begin
                errors++;
                $display("FAIL rand_comb[%0d]: p_ready=%0b m_ready=%0b hazard=%0b, required %0b/%0b/%0b", c, p_ready, m_ready, hazard, epg, emg, ehz);
            end
            advance();
            checks++;
            if (rf_we !== exp_we || pending !== mpend || (exp_we && (rf_wa !== exp_wa || rf_wd !== exp_wd))) begin
                errors++;
                $display("FAIL rand_reg[%0d]: we=%0b wa=%0d wd=%h pend=%h, required %0b/%0d/%h/%h", c, rf_we, rf_wa, rf_wd, pending, exp_we, exp_wa, exp_wd, mpend);
            end
        end
        idle();
        advance();
    endtask

    initial begin
        test_reset();
        test_r0_drop();
        test_contention();
        test_scoreboard();
        test_same_cycle();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single RegFile write port (we/wa/wd) between the in-order pipeline writeback stage (P) and the multi-cycle mult/div unit (M).
- Uses fixed P-priority with a starvation guard for M.
- Keeps a 32-bit pending-write scoreboard for in-flight M ops, so decode can stall on RAW hazards.
- Sits between the writeback muxing and RegFile; rf_* outputs connect directly to RegFile we/wa/wd.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles M may be held off by P before M is force-granted (1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p_valid  in  1  pipeline writeback request
- p_wa  in  5  pipeline destination register
- p_wd  in  32  pipeline write data
- p_ready  out  1  pipeline request accepted this cycle (combinational)
- m_valid  in  1  mult/div writeback request
- m_wa  in  5  mult/div destination register
- m_wd  in  32  mult/div write data
- m_ready  out  1  mult/div request accepted this cycle (combinational)
- m_issue  in  1  mult/div op issued this cycle
- m_issue_wa  in  5  destination of issued op
- ra1  in  5  decode read address 1
- ra2  in  5  decode read address 2
- hazard  out  1  ra1 or ra2 has a pending M write (combinational)
- pending  out  32  scoreboard, bit i = reg i awaiting M write
- rf_we  out  1  RegFile write enable (registered)
- rf_wa  out  5  RegFile write address (registered)
- rf_wd  out  32  RegFile write data (registered)

Behaviour:
- Reset (rst_n=0, async): rf_we=0, rf_wa=0, rf_wd=0, pending=0, starve counter=0, state=P_PRI. Reset mid-transfer drops the in-flight write; rf_we falls immediately.
- Transfer occurs when valid && ready. At most one of p_ready/m_ready is high per cycle. A ready is never high without its valid.
- State P_PRI:
  - p_valid → grant P.
  - else m_valid → grant M.
  - Counter increments on each cycle where m_valid && P granted, saturating at STARVE_LIMIT.
  - Counter resets to 0 on any M grant or when m_valid=0.
  - Counter reaching STARVE_LIMIT → next state M_PRI.
- State M_PRI:
  - m_valid → grant M, return to P_PRI, counter=0.
  - m_valid dropped → return to P_PRI, no grant forced.
  - P is granted only if m_valid=0.
- Output latency is 1 cycle. A transfer in cycle N drives rf_we=1 with rf_wa/rf_wd in cycle N+1, so RegFile commits at the end of N+1. rf_we=0 on cycles following no transfer.
- Writes to r0 are accepted (ready=1) but produce rf_we=0. rf_wa/rf_wd still update.
- Scoreboard:
  - m_issue sets pending[m_issue_wa].
  - An accepted M transfer clears pending[m_wa].
  - Issue and commit to the same register in the same cycle: set wins (newer op).
  - Issue to r0 is ignored; pending[0] is always 0.
  - Issue to a register already pending keeps the bit set (single outstanding M op per register is guaranteed upstream).
- hazard = pending[ra1] | pending[ra2], using the current registered pending value. There is no bypass of same-cycle commit; hazard clears the cycle after the commit transfer.
- Only M transfers clear pending bits; P writes to a pending register leave pending unchanged.
- Held requests: a valid requester not granted must hold wa/wd stable. The arbiter does not latch unaccepted requests.

Test Plan:
- Reset → assert rst_n=0 mid-cycle with p_valid=1 → rf_we=0, pending=0 immediately. After release, a P write (r3, 0x45) gives p_ready=1 and, one cycle later, rf_we=1, rf_wa=3, rf_wd=0x45.
- r0 drop → P write (r0, 69) → p_ready=1, next cycle rf_we=0. M write to r0 behaves the same. A subsequent m_issue to r0 leaves pending=0.
- Contention → p_valid and m_valid held high continuously (STARVE_LIMIT=4) → P granted 4 cycles, M granted on the 5th, then P resumes. Only one ready is high per cycle.
- Scoreboard → m_issue r5; next cycle ra1=5 → hazard=1. M commit (r5, 0xDEAD) accepted → hazard=1 that cycle, 0 next. rf_wd=0xDEAD and pending[5]=0 the cycle after acceptance.
- Same-cycle set/clear → pending[7]=1; m_issue r7 together with accepted M commit r7 → pending[7] stays 1. A commit to r7 alone then clears it.
- Back-to-back → P writes r1=1, r2=2, r3=3 on consecutive cycles → rf_we=1 for three consecutive cycles with matching wa/wd, lagging by one cycle.
